// File: rtl/bern_keystream_gen.sv
// Bernoulli-map key generator: iterates a doubling map over a seed a programmable
// number of rounds and hands each key out on a valid/ready port, optionally streaming.
module bern_keystream_gen #(
    parameter int unsigned  W        = 80,
    parameter int unsigned  RW       = 8,
    parameter logic [W-1:0] TAP_MASK = (W'(3) << (W - 2)) | W'(3)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [W-1:0]  seed,
    input  logic [RW-1:0] rounds,
    input  logic          mode,
    input  logic          stream,
    output logic [W-1:0]  key_out,
    output logic          key_valid,
    input  logic          key_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  key_q;
    logic [RW-1:0] cnt_q;
    logic [RW-1:0] rounds_q;
    logic          mode_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    logic [RW-1:0] start_cnt_d;
    logic [RW-1:0] reload_cnt_d;

    // Adding 2^(W-1) mod 2^W only flips the top bit of the shifted value.
    function automatic logic [W-1:0] map_step(
        input logic [W-1:0] x,
        input logic         pert
    );
        logic [W-1:0] y;
        y = x << 1;
        if (x[W-1:W-2] != 2'b00) begin
            y[W-1] = ~y[W-1];
        end
        if (pert) begin
            y[0] = ^(x & TAP_MASK);
        end
        return y;
    endfunction

    assign start_cnt_d  = (rounds == '0)   ? RW'(1) : rounds;
    assign reload_cnt_d = (rounds_q == '0) ? RW'(1) : rounds_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            key_q    <= '0;
            cnt_q    <= '0;
            rounds_q <= '0;
            mode_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q    <= seed;
                        cnt_q    <= start_cnt_d;
                        rounds_q <= rounds;
                        mode_q   <= mode;
                        busy_q   <= 1'b1;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    key_q <= map_step(key_q, mode_q);
                    cnt_q <= cnt_q - RW'(1);
                    if (cnt_q == RW'(1)) begin
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (key_ready) begin
                        valid_q <= 1'b0;
                        if (stream) begin
                            cnt_q   <= reload_cnt_d;
                            state_q <= ITER;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign key_out   = key_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bern_keystream_gen.sv
// Directed bench for bern_keystream_gen: single keys, round counts,
// perturbed mode, streaming with backpressure, and mid-run reset.
module tb_bern_keystream_gen;

    localparam int W  = 80;
    localparam int RW = 8;

    logic          Clk;
    logic          Reset;
    logic          start;
    logic [W-1:0]  seed;
    logic [RW-1:0] rounds;
    logic          mode;
    logic          stream;
    logic [W-1:0]  key_out;
    logic          key_valid;
    logic          key_ready;
    logic          busy;
    logic          done;

    int n_chk;
    int n_err;

    bern_keystream_gen #(
        .W  (W),
        .RW (RW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .seed      (seed),
        .rounds    (rounds),
        .mode      (mode),
        .stream    (stream),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(
        input string        tag,
        input logic [W-1:0] got,
        input logic [W-1:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_one(
        input string         tag,
        input logic [W-1:0]  s,
        input logic [RW-1:0] r,
        input logic          m,
        input logic [W-1:0]  ek,
        input int            elat
    );
        int lat;
        seed      = s;
        rounds    = r;
        mode      = m;
        stream    = 1'b0;
        key_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, W'(busy), W'(1));
        lat = 0;
        while (!key_valid && lat < 300) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, W'(lat), W'(elat));
        chk({tag, "_key"}, key_out, ek);
        step();
        chk({tag, "_done"}, W'(done), W'(1));
        chk({tag, "_vld0"}, W'(key_valid), W'(0));
        chk({tag, "_idle"}, W'(busy), W'(0));
        step();
        chk({tag, "_done0"}, W'(done), W'(0));
    endtask

    logic [W-1:0] exp_keys [3];
    int gap;

    initial begin
        n_chk     = 0;
        n_err     = 0;
        Reset     = 1'b1;
        start     = 1'b0;
        seed      = '0;
        rounds    = '0;
        mode      = 1'b0;
        stream    = 1'b0;
        key_ready = 1'b0;
        step();
        step();
        chk("rst_key", key_out, W'(0));
        chk("rst_vld", W'(key_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        Reset = 1'b0;
        step();

        run_one("t1", W'(1), 8'd1, 1'b0, W'(2), 1);
        run_one("t2a", {4'h6, 76'h0}, 8'd1, 1'b0, {4'h4, 76'h0}, 1);
        run_one("t2b", {4'h4, 76'h0}, 8'd1, 1'b0, W'(0), 1);
        run_one("t3", {4'h8, 76'h0}, 8'd1, 1'b1, {4'h8, 76'h1}, 1);
        run_one("t4r0", W'(1), 8'd0, 1'b0, W'(2), 1);
        run_one("t4r3", W'(1), 8'd3, 1'b0, W'(8), 3);
        run_one("pert2", W'(1), 8'd2, 1'b1, W'(6), 2);

        exp_keys[0] = W'('h4);
        exp_keys[1] = W'('h10);
        exp_keys[2] = W'('h40);
        seed      = W'(1);
        rounds    = 8'd2;
        mode      = 1'b0;
        stream    = 1'b1;
        key_ready = 1'b1;
        start     = 1'b1;
        step();
        seed   = '1;
        rounds = 8'd7;
        mode   = 1'b1;
        gap = 0;
        while (!key_valid && gap < 300) begin
            step();
            gap++;
        end
        chk("t5_lat0", W'(gap), W'(2));
        chk("t5_key0", key_out, exp_keys[0]);
        for (int k = 1; k < 3; k++) begin
            gap = 0;
            do begin
                step();
                gap++;
            end while (!key_valid && gap < 300);
            chk($sformatf("t5_gap%0d", k), W'(gap), W'(3));
            chk($sformatf("t5_key%0d", k), key_out, exp_keys[k]);
        end
        key_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t5_hold_v%0d", k), W'(key_valid), W'(1));
            chk($sformatf("t5_hold_k%0d", k), key_out, exp_keys[2]);
        end
        start     = 1'b0;
        stream    = 1'b0;
        key_ready = 1'b1;
        step();
        chk("t5_done", W'(done), W'(1));
        chk("t5_idle", W'(busy), W'(0));
        step();

        seed      = W'(1);
        rounds    = 8'd5;
        mode      = 1'b0;
        stream    = 1'b0;
        key_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t6_busy", W'(busy), W'(1));
        Reset = 1'b1;
        #1;
        chk("t6_key", key_out, W'(0));
        chk("t6_vld", W'(key_valid), W'(0));
        chk("t6_busy0", W'(busy), W'(0));
        chk("t6_done", W'(done), W'(0));
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("t6_nodone%0d", k), W'(done), W'(0));
        end
        run_one("t6_re", W'(1), 8'd1, 1'b0, W'(2), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
